// File: rtl/ram_arbiter.sv
// ram_arbiter
// ---------------------------------------------------------------------------
// Shares one single-port RAM macro (active-low CSb/WEb) between two
// requesters: port A (wishbone slave side) and port B (GPIO pattern
// sequencer). Only one transaction is in flight at a time. Every signal
// driven towards the RAM comes straight from a flop, so the macro sees clean
// edges. Tie-breaks are round-robin, or fixed in favour of A when FIXED_PRIO
// is set.
//
// Parameters
//   AW          RAM word-address width
//   DW          RAM data width
//   RD_LAT      RAM read latency in cycles after the CSb-low cycle (1..7)
//   FIXED_PRIO  0 = round-robin on ties, 1 = port A always wins ties
//
// Ports
//   CLK_I, RST_I                 clock (rising edge), async active-high reset
//   A_REQ / B_REQ                request, held with stable fields until ACK
//   A_WE / B_WE                  1 = write, 0 = read
//   A_ADDR / B_ADDR              word address
//   A_DATA_IN / B_DATA_IN        write data
//   A_DATA_OUT / B_DATA_OUT      registered read data, held after ACK
//   A_ACK / B_ACK                one-cycle completion pulse
//   BUSY                         high whenever the arbiter is not idle
//   RAM_CSb, RAM_WEb             RAM chip select / write enable, active low
//   RAM_ADDR, RAM_DATA_IN        RAM address and write data
//   RAM_DATA_OUT                 RAM read data
// ---------------------------------------------------------------------------
module ram_arbiter #(
    parameter int AW         = 8,
    parameter int DW         = 32,
    parameter int RD_LAT     = 1,
    parameter int FIXED_PRIO = 0
) (
    input  logic          CLK_I,
    input  logic          RST_I,
    input  logic          A_REQ,
    input  logic          A_WE,
    input  logic [AW-1:0] A_ADDR,
    input  logic [DW-1:0] A_DATA_IN,
    output logic [DW-1:0] A_DATA_OUT,
    output logic          A_ACK,
    input  logic          B_REQ,
    input  logic          B_WE,
    input  logic [AW-1:0] B_ADDR,
    input  logic [DW-1:0] B_DATA_IN,
    output logic [DW-1:0] B_DATA_OUT,
    output logic          B_ACK,
    output logic          BUSY,
    output logic          RAM_CSb,
    output logic          RAM_WEb,
    output logic [AW-1:0] RAM_ADDR,
    output logic [DW-1:0] RAM_DATA_IN,
    input  logic [DW-1:0] RAM_DATA_OUT
);

    // Read-latency countdown start value; 3 bits covers the legal range 1..7.
    localparam logic [2:0] LAT_INIT = 3'(RD_LAT);
    localparam logic       FIXED    = (FIXED_PRIO != 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic          winnerB_q, winnerB_d;   // 1 = port B owns the current transaction
    logic          lastB_q, lastB_d;       // 1 = port B was served most recently
    logic          isWrite_q, isWrite_d;
    logic [2:0]    cnt_q, cnt_d;
    logic          ramCsb_q, ramCsb_d;
    logic          ramWeb_q, ramWeb_d;
    logic [AW-1:0] ramAddr_q, ramAddr_d;
    logic [DW-1:0] ramDin_q, ramDin_d;
    logic          aAck_q, aAck_d;
    logic          bAck_q, bAck_d;
    logic [DW-1:0] aDout_q, aDout_d;
    logic [DW-1:0] bDout_q, bDout_d;

    logic          grantB;
    logic          winWe;
    logic [AW-1:0] winAddr;
    logic [DW-1:0] winData;

    // Arbitration: B wins when it is the only requester, or on a tie when
    // round-robin is active and A was the last one served. Fixed priority
    // hands every tie to A, so B waits until A stops requesting.
    assign grantB  = B_REQ & (~A_REQ | (~FIXED & ~lastB_q));
    assign winWe   = grantB ? B_WE      : A_WE;
    assign winAddr = grantB ? B_ADDR    : A_ADDR;
    assign winData = grantB ? B_DATA_IN : A_DATA_IN;

    // Next-state and output logic. The request fields are only looked at in
    // IDLE; once a transaction is granted everything the RAM sees comes from
    // the registers loaded at that edge, so a requester changing its fields
    // mid-transaction has no effect. CSb/WEb are pulled low for exactly the
    // ACCESS cycle and released at the end of it.
    always_comb begin
        state_d   = state_q;
        winnerB_d = winnerB_q;
        lastB_d   = lastB_q;
        isWrite_d = isWrite_q;
        cnt_d     = cnt_q;
        ramCsb_d  = ramCsb_q;
        ramWeb_d  = ramWeb_q;
        ramAddr_d = ramAddr_q;
        ramDin_d  = ramDin_q;
        aAck_d    = aAck_q;
        bAck_d    = bAck_q;
        aDout_d   = aDout_q;
        bDout_d   = bDout_q;

        case (state_q)
            IDLE: begin
                if (A_REQ || B_REQ) begin
                    winnerB_d = grantB;
                    lastB_d   = grantB;
                    isWrite_d = winWe;
                    ramAddr_d = winAddr;
                    ramDin_d  = winData;
                    ramCsb_d  = 1'b0;
                    ramWeb_d  = ~winWe;
                    state_d   = ACCESS;
                end
            end

            ACCESS: begin
                ramCsb_d = 1'b1;
                ramWeb_d = 1'b1;
                if (isWrite_q) begin
                    aAck_d  = ~winnerB_q;
                    bAck_d  = winnerB_q;
                    state_d = DONE;
                end else begin
                    cnt_d   = LAT_INIT;
                    state_d = WAIT;
                end
            end

            WAIT: begin
                // The count reaches 1 on the edge where the RAM output is
                // valid; data is captured there and nowhere else.
                if (cnt_q == 3'd1) begin
                    if (winnerB_q) begin
                        bDout_d = RAM_DATA_OUT;
                        bAck_d  = 1'b1;
                    end else begin
                        aDout_d = RAM_DATA_OUT;
                        aAck_d  = 1'b1;
                    end
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end

            DONE: begin
                // Requests are ignored here so the requester has one edge to
                // drop REQ after seeing ACK without starting a new transaction.
                aAck_d  = 1'b0;
                bAck_d  = 1'b0;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers. Reset abandons any transaction in flight
    // without acknowledging it and leaves last-served pointing at B so that
    // A wins the first tie after reset.
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state_q   <= IDLE;
            winnerB_q <= 1'b0;
            lastB_q   <= 1'b1;
            isWrite_q <= 1'b0;
            cnt_q     <= 3'd0;
            ramCsb_q  <= 1'b1;
            ramWeb_q  <= 1'b1;
            ramAddr_q <= '0;
            ramDin_q  <= '0;
            aAck_q    <= 1'b0;
            bAck_q    <= 1'b0;
            aDout_q   <= '0;
            bDout_q   <= '0;
        end else begin
            state_q   <= state_d;
            winnerB_q <= winnerB_d;
            lastB_q   <= lastB_d;
            isWrite_q <= isWrite_d;
            cnt_q     <= cnt_d;
            ramCsb_q  <= ramCsb_d;
            ramWeb_q  <= ramWeb_d;
            ramAddr_q <= ramAddr_d;
            ramDin_q  <= ramDin_d;
            aAck_q    <= aAck_d;
            bAck_q    <= bAck_d;
            aDout_q   <= aDout_d;
            bDout_q   <= bDout_d;
        end
    end

    assign BUSY        = (state_q != IDLE);
    assign RAM_CSb     = ramCsb_q;
    assign RAM_WEb     = ramWeb_q;
    assign RAM_ADDR    = ramAddr_q;
    assign RAM_DATA_IN = ramDin_q;
    assign A_ACK       = aAck_q;
    assign B_ACK       = bAck_q;
    assign A_DATA_OUT  = aDout_q;
    assign B_DATA_OUT  = bDout_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter
// ---------------------------------------------------------------------------
// Drives two arbiter instances side by side: index 0 is round-robin with a
// one-cycle RAM, index 1 is fixed-priority with a three-cycle RAM. Each
// instance has its own behavioural RAM whose read port shows a junk word
// except on the one cycle the requested data is valid. Stimulus pushes the
// expected port, completion edge and read data into a per-instance queue;
// the monitor pops on every ACK.
// ---------------------------------------------------------------------------
module tb_ram_arbiter;

    localparam int LAT0 = 1;
    localparam int LAT1 = 3;

    typedef struct {
        int          port;
        int          edgeNo;
        bit          chk;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    // Requester-side inputs, indexed [instance][port], port 0 = A, 1 = B.
    logic        req   [2][2];
    logic        we    [2][2];
    logic [7:0]  addr  [2][2];
    logic [31:0] wdata [2][2];

    // DUT outputs.
    logic [1:0][1:0]       ack;
    logic [1:0][1:0][31:0] dout;
    logic [1:0]            busy;
    logic [1:0]            ramCsb;
    logic [1:0]            ramWeb;
    logic [1:0][7:0]       ramAddr;
    logic [1:0][31:0]      ramDin;
    logic [31:0]           ramRd [2];

    // RAM model state.
    logic [31:0] mem   [2][256];
    logic [31:0] pipeD [2][8];
    logic        pipeV [2][8];

    exp_t        sb0 [$];
    exp_t        sb1 [$];
    logic [31:0] expDout [2][2];
    int          total = 0;
    int          bad = 0;
    int          csLow [2];
    int          txCount [2];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    ram_arbiter #(.AW(8), .DW(32), .RD_LAT(LAT0), .FIXED_PRIO(0)) dutRr (
        .CLK_I(clk), .RST_I(rst),
        .A_REQ(req[0][0]), .A_WE(we[0][0]), .A_ADDR(addr[0][0]), .A_DATA_IN(wdata[0][0]),
        .A_DATA_OUT(dout[0][0]), .A_ACK(ack[0][0]),
        .B_REQ(req[0][1]), .B_WE(we[0][1]), .B_ADDR(addr[0][1]), .B_DATA_IN(wdata[0][1]),
        .B_DATA_OUT(dout[0][1]), .B_ACK(ack[0][1]),
        .BUSY(busy[0]), .RAM_CSb(ramCsb[0]), .RAM_WEb(ramWeb[0]),
        .RAM_ADDR(ramAddr[0]), .RAM_DATA_IN(ramDin[0]), .RAM_DATA_OUT(ramRd[0])
    );

    ram_arbiter #(.AW(8), .DW(32), .RD_LAT(LAT1), .FIXED_PRIO(1)) dutFix (
        .CLK_I(clk), .RST_I(rst),
        .A_REQ(req[1][0]), .A_WE(we[1][0]), .A_ADDR(addr[1][0]), .A_DATA_IN(wdata[1][0]),
        .A_DATA_OUT(dout[1][0]), .A_ACK(ack[1][0]),
        .B_REQ(req[1][1]), .B_WE(we[1][1]), .B_ADDR(addr[1][1]), .B_DATA_IN(wdata[1][1]),
        .B_DATA_OUT(dout[1][1]), .B_ACK(ack[1][1]),
        .BUSY(busy[1]), .RAM_CSb(ramCsb[1]), .RAM_WEb(ramWeb[1]),
        .RAM_ADDR(ramAddr[1]), .RAM_DATA_IN(ramDin[1]), .RAM_DATA_OUT(ramRd[1])
    );

    // Behavioural RAMs: write on a CSb/WEb-low edge; a read sampled on a
    // CSb-low edge walks down a shift pipe and is visible for one cycle only.
    always @(posedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (!ramCsb[g] && !ramWeb[g]) mem[g][ramAddr[g]] <= ramDin[g];
            pipeV[g][0] <= rst ? 1'b0 : (!ramCsb[g] && ramWeb[g]);
            pipeD[g][0] <= mem[g][ramAddr[g]];
            for (int s = 1; s < 8; s++) begin
                pipeV[g][s] <= rst ? 1'b0 : pipeV[g][s-1];
                pipeD[g][s] <= pipeD[g][s-1];
            end
        end
    end

    always_comb begin
        int idx;
        idx = 0;
        ramRd[0] = '0;
        ramRd[1] = '0;
        for (int g = 0; g < 2; g++) begin
            idx = (g == 0) ? LAT0 - 1 : LAT1 - 1;
            ramRd[g] = pipeV[g][idx] ? pipeD[g][idx] : 32'hBADC0DE0;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic expectAck(input int g, input int p, input int edgeNo, input bit chk, input logic [31:0] d);
        exp_t e;
        e.port = p;
        e.edgeNo = edgeNo;
        e.chk = chk;
        e.data = d;
        if (g == 0) sb0.push_back(e);
        else sb1.push_back(e);
    endtask

    task automatic popCheck(input int g, input int p);
        exp_t e;
        int   n;
        n = (g == 0) ? sb0.size() : sb1.size();
        if (n == 0) begin
            checkOutput($sformatf("unexpectedAck i%0d p%0d", g, p), 32'd1, 32'd0);
        end else begin
            e = (g == 0) ? sb0.pop_front() : sb1.pop_front();
            checkOutput($sformatf("ackPort i%0d", g), 32'(p), 32'(e.port));
            checkOutput($sformatf("ackEdge i%0d p%0d", g, p), 32'(cyc), 32'(e.edgeNo));
            if (e.chk) expDout[g][p] = e.data;
        end
    endtask

    // Monitor: samples on the falling edge, pops the scoreboard on every ACK
    // and checks the bus invariants and the held read data every cycle.
    initial begin
        for (int g = 0; g < 2; g++) begin
            csLow[g] = 0;
            for (int p = 0; p < 2; p++) expDout[g][p] = '0;
        end
        forever begin
            @(negedge clk);
            for (int g = 0; g < 2; g++) begin
                if (rst) begin
                    expDout[g][0] = '0;
                    expDout[g][1] = '0;
                end else begin
                    checkOutput($sformatf("ackOverlap i%0d", g), 32'(ack[g][0] & ack[g][1]), 32'd0);
                    checkOutput($sformatf("webWithoutCs i%0d", g), 32'(ramCsb[g] & ~ramWeb[g]), 32'd0);
                    if (!ramCsb[g]) csLow[g]++;
                    for (int p = 0; p < 2; p++) begin
                        if (ack[g][p]) popCheck(g, p);
                        checkOutput($sformatf("dataOut i%0d p%0d", g, p), dout[g][p], expDout[g][p]);
                    end
                end
            end
        end
    end

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic waitAck(input int g, input int p);
        for (int n = 0; n < 40; n++) begin
            @(posedge clk);
            #1;
            if (ack[g][p]) break;
        end
        checkOutput($sformatf("ackSeen i%0d p%0d", g, p), 32'(ack[g][p]), 32'd1);
    endtask

    // One requester transaction; keep leaves REQ high for a follow-on request.
    task automatic applyStimulus(input int g, input int p, input logic w, input logic [7:0] a,
                                 input logic [31:0] d, input bit keep);
        we[g][p]    = w;
        addr[g][p]  = a;
        wdata[g][p] = d;
        req[g][p]   = 1'b1;
        waitAck(g, p);
        if (!keep) req[g][p] = 1'b0;
        txCount[g]++;
    endtask

    task automatic writeWord(input int g, input int p, input logic [7:0] a, input logic [31:0] d);
        int k;
        k = cyc;
        expectAck(g, p, k + 2, 1'b0, '0);
        applyStimulus(g, p, 1'b1, a, d, 1'b0);
        idleCycles(2);
    endtask

    task automatic readWord(input int g, input int p, input logic [7:0] a, input logic [31:0] d, input int lat);
        int k;
        k = cyc;
        expectAck(g, p, k + 2 + lat, 1'b1, d);
        applyStimulus(g, p, 1'b0, a, '0, 1'b0);
        idleCycles(2);
    endtask

    task automatic checkResetState(input int g);
        checkOutput($sformatf("rstCsb i%0d", g), 32'(ramCsb[g]), 32'd1);
        checkOutput($sformatf("rstWeb i%0d", g), 32'(ramWeb[g]), 32'd1);
        checkOutput($sformatf("rstAddr i%0d", g), 32'(ramAddr[g]), 32'd0);
        checkOutput($sformatf("rstDin i%0d", g), ramDin[g], 32'd0);
        checkOutput($sformatf("rstAck i%0d", g), 32'(ack[g]), 32'd0);
        checkOutput($sformatf("rstDoutA i%0d", g), dout[g][0], 32'd0);
        checkOutput($sformatf("rstDoutB i%0d", g), dout[g][1], 32'd0);
        checkOutput($sformatf("rstBusy i%0d", g), 32'(busy[g]), 32'd0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int k;
        for (int g = 0; g < 2; g++) begin
            txCount[g] = 0;
            for (int p = 0; p < 2; p++) begin
                req[g][p] = 1'b0;
                we[g][p] = 1'b0;
                addr[g][p] = '0;
                wdata[g][p] = '0;
            end
        end
        rst = 1'b1;
        idleCycles(3);
        checkResetState(0);
        checkResetState(1);
        rst = 1'b0;
        idleCycles(2);

        // Write then read back through A on the single-cycle RAM.
        writeWord(0, 0, 8'h85, 32'hDEADBEEF);
        readWord(0, 0, 8'h85, 32'hDEADBEEF, LAT0);
        checkOutput("doutHeld", dout[0][0], 32'hDEADBEEF);

        // Fresh reset, then both ports held: round-robin must alternate A,B,A,B.
        rst = 1'b1;
        idleCycles(2);
        rst = 1'b0;
        idleCycles(1);
        k = cyc;
        expectAck(0, 0, k + 2, 1'b0, '0);
        expectAck(0, 1, k + 5, 1'b0, '0);
        expectAck(0, 0, k + 8, 1'b0, '0);
        expectAck(0, 1, k + 11, 1'b0, '0);
        fork
            begin
                applyStimulus(0, 0, 1'b1, 8'h01, 32'hA0000001, 1'b1);
                applyStimulus(0, 0, 1'b1, 8'h02, 32'hA0000002, 1'b0);
            end
            begin
                applyStimulus(0, 1, 1'b1, 8'h81, 32'hB0000081, 1'b1);
                applyStimulus(0, 1, 1'b1, 8'h82, 32'hB0000082, 1'b0);
            end
        join
        idleCycles(2);
        readWord(0, 1, 8'h01, 32'hA0000001, LAT0);
        readWord(0, 0, 8'h82, 32'hB0000082, LAT0);
        readWord(0, 0, 8'h02, 32'hA0000002, LAT0);
        readWord(0, 1, 8'h81, 32'hB0000081, LAT0);

        // B alters its fields during ACCESS; the granted values must stick.
        writeWord(0, 0, 8'h20, 32'h55AA55AA);
        k = cyc;
        expectAck(0, 1, k + 2, 1'b0, '0);
        we[0][1] = 1'b1;
        addr[0][1] = 8'h10;
        wdata[0][1] = 32'h11112222;
        req[0][1] = 1'b1;
        idleCycles(1);
        addr[0][1] = 8'h20;
        wdata[0][1] = 32'h33334444;
        #1;
        checkOutput("accessCsb", 32'(ramCsb[0]), 32'd0);
        checkOutput("accessWeb", 32'(ramWeb[0]), 32'd0);
        checkOutput("grantAddr", 32'(ramAddr[0]), 32'h10);
        checkOutput("grantData", ramDin[0], 32'h11112222);
        waitAck(0, 1);
        req[0][1] = 1'b0;
        txCount[0]++;
        checkOutput("addrHoldDone", 32'(ramAddr[0]), 32'h10);
        idleCycles(2);
        readWord(0, 1, 8'h10, 32'h11112222, LAT0);
        readWord(0, 0, 8'h20, 32'h55AA55AA, LAT0);

        // Three-cycle RAM: read ACK lands four edges after the grant.
        writeWord(1, 0, 8'h33, 32'hCAFEF00D);
        readWord(1, 1, 8'h33, 32'hCAFEF00D, LAT1);

        // Fixed priority: A back-to-back starves B until A lets go.
        k = cyc;
        expectAck(1, 0, k + 2, 1'b0, '0);
        expectAck(1, 0, k + 5, 1'b0, '0);
        expectAck(1, 0, k + 8, 1'b0, '0);
        expectAck(1, 1, k + 11, 1'b0, '0);
        fork
            begin
                applyStimulus(1, 0, 1'b1, 8'h40, 32'hC0000040, 1'b1);
                applyStimulus(1, 0, 1'b1, 8'h41, 32'hC0000041, 1'b1);
                applyStimulus(1, 0, 1'b1, 8'h42, 32'hC0000042, 1'b0);
            end
            begin
                applyStimulus(1, 1, 1'b1, 8'h50, 32'hD0000050, 1'b0);
            end
        join
        idleCycles(2);
        readWord(1, 0, 8'h50, 32'hD0000050, LAT1);
        readWord(1, 1, 8'h42, 32'hC0000042, LAT1);

        // Reset while a read waits on the RAM: dropped without an ACK.
        we[1][0] = 1'b0;
        addr[1][0] = 8'h33;
        req[1][0] = 1'b1;
        txCount[1]++;
        idleCycles(2);
        checkOutput("busyInWait", 32'(busy[1]), 32'd1);
        checkOutput("csbInWait", 32'(ramCsb[1]), 32'd1);
        rst = 1'b1;
        req[1][0] = 1'b0;
        #1;
        checkResetState(1);
        idleCycles(1);
        rst = 1'b0;
        idleCycles(1);
        checkOutput("idleAfterReset", 32'(busy[1]), 32'd0);
        idleCycles(6);
        readWord(1, 1, 8'h42, 32'hC0000042, LAT1);

        idleCycles(3);
        checkOutput("sb0Drained", 32'(sb0.size()), 32'd0);
        checkOutput("sb1Drained", 32'(sb1.size()), 32'd0);
        checkOutput("csLowCount i0", 32'(csLow[0]), 32'(txCount[0]));
        checkOutput("csLowCount i1", 32'(csLow[1]), 32'(txCount[1]));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
